if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry instruction queue between fetch and decode, followed by a registered ID-side output stage.
- Fetch keeps running while decode is stalled, until the queue is full; a redirect flush discards all in-flight instructions.
- ID sees registered pc/inst exactly as before. A zero word marks a bubble (NOP), and an explicit valid bit accompanies it.

Parameters:
- ADDR_W, 32, width of pc.
- INST_W, 32, width of instruction word.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch/exception redirect; discard all held instructions.
- if_valid  in  1  fetch presents an instruction this cycle.
- if_pc  in  ADDR_W  pc of fetched instruction.
- if_inst  in  INST_W  fetched instruction.
- if_ready  out  1  queue can accept; equals !full, registered-state based.
- id_stall  in  1  decode stage stalled (stall-controller bit for ID); hold output.
- id_valid  out  1  id_pc/id_inst hold a real instruction.
- id_pc  out  ADDR_W  pc to decode.
- id_inst  out  INST_W  instruction to decode.
- count  out  CNT_W  queue occupancy (excludes output register).

Behaviour:
- Reset (rst=1 at posedge, synchronous, active-high; clock clk):
  - id_pc = 0, id_inst = 0, id_valid = 0.
  - Queue empty: count = 0, rd_ptr = wr_ptr = 0, if_ready = 1.
  - Reset mid-operation discards all contents in one cycle.
- Priority at each posedge: rst > flush > normal operation.
- Flush:
  - Next cycle: queue empty, id_pc = 0, id_inst = 0, id_valid = 0.
  - if_valid in the flush cycle is ignored, even if the queue is empty.
  - if_ready = 1 in the cycle after the flush.
- Accept: push = if_valid && if_ready. if_ready depends only on the registered count, so there is no combinational path from id_stall.
- Output advance when id_stall = 0:
  - Queue non-empty: load the head entry into id_* with id_valid = 1, and pop.
  - Queue empty and push: bypass. The fetched instruction goes straight into id_*, id_valid = 1, and is not enqueued.
  - Otherwise: bubble. id_pc = 0, id_inst = 0, id_valid = 0.
- id_stall = 1: id_* hold their values. Pushes continue until full.
- Simultaneous push and pop with the queue non-empty: write at wr_ptr, read at rd_ptr, count unchanged.
  - When full, if_ready = 0, so push cannot occur even though a pop frees a slot. That slot becomes visible next cycle.
- Pointers: log2(DEPTH) bits, wrapping naturally modulo DEPTH. count saturates only by construction and never exceeds DEPTH.
- Latency: 1 cycle from fetch to id_* when empty and not stalled; otherwise FIFO order, strictly in-order.
- Order invariant: the output never reorders. A bypass is permitted only when count = 0.

Decomposition:
- Shared header: ZeroWord, RstEnable, Stop/NoStop, InstAddrBus/InstBus widths.
- Sub-module sync_fifo_mem: DEPTH x (ADDR_W+INST_W) storage with registered write and asynchronous read at rd_ptr.
- Pointer/count control and the output stage stay in if_id_queue.

Test Plan:
- Reset: drive rst=1 for 2 cycles with if_valid=1 -> id_valid=0, id_inst=0, count=0, if_ready=1.
- Flow-through: id_stall=0, push pc 0x100..0x10C on consecutive cycles -> id_pc follows 1 cycle later (0x100 at cycle+1), count stays 0.
- Stall fill: id_stall=1 and push 6 instructions -> count reaches 4, if_ready=0 after the 4th push, 5th/6th not accepted, id_* held. Release the stall -> 4 entries drain in order, one per cycle, followed by a bubble with id_inst=0.
- Full with simultaneous pop: count=4, id_stall=0, if_valid=1 -> no push that cycle, count=3, if_ready=1 next cycle.
- Flush: count=3 with id_valid=1, assert flush with if_valid=1 -> next cycle count=0, id_valid=0, id_inst=0. The instruction from the flush cycle never appears.
- Wrap-around: stream 3*DEPTH instructions with random id_stall -> output sequence equals input sequence with no loss or duplication, verified by the scoreboard.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue: bus widths, reset/stall
// encodings and the output-stage load selector.
package if_id_queue_pkg;

    localparam int unsigned InstAddrBusW = 32;
    localparam int unsigned InstBusW     = 32;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;

    // What the ID-side register loads at the next edge
    typedef enum logic [1:0] {
        OUT_HOLD   = 2'd0,
        OUT_HEAD   = 2'd1,
        OUT_BYPASS = 2'd2,
        OUT_BUBBLE = 2'd3
    } out_sel_e;

endpackage

// File: rtl/if_id_queue_sync_fifo_mem.sv
// Queue storage: DEPTH words with a registered write port and an
// asynchronous read port addressed by the read pointer.
module if_id_queue_sync_fifo_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents need no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry instruction queue between fetch and decode with a registered
// ID-side output stage; empty-queue fetches bypass straight into the output.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBusW,
    parameter int unsigned INST_W = InstBusW,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_if_valid,
    input  logic [ADDR_W-1:0] i_if_pc,
    input  logic [INST_W-1:0] i_if_inst,
    output logic              o_if_ready,
    input  logic              i_id_stall,
    output logic              o_id_valid,
    output logic [ADDR_W-1:0] o_id_pc,
    output logic [INST_W-1:0] o_id_inst,
    output logic [CNT_W-1:0]  o_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned DATA_W = ADDR_W + INST_W;

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_if_ready;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;

    logic              w_empty;
    logic              w_hold;
    logic              w_push;
    logic              w_pop;
    logic              w_bypass;
    logic              w_enq;
    logic              w_mem_we;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_head;
    logic [ADDR_W-1:0] w_head_pc;
    logic [INST_W-1:0] w_head_inst;
    out_sel_e          w_out_sel;

    // Handshake, pop/bypass decision and next occupancy
    always_comb begin
        w_empty     = (r_count == '0);
        w_hold      = (i_id_stall == Stop);
        w_push      = i_if_valid && r_if_ready;
        w_pop       = !w_hold && !w_empty;
        w_bypass    = !w_hold && w_empty && w_push;
        w_enq       = w_push && !w_bypass;
        w_count_nxt = r_count;
        if (w_enq && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_enq && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end

        w_out_sel = OUT_HOLD;
        if (!w_hold) begin
            if (!w_empty) begin
                w_out_sel = OUT_HEAD;
            end else if (w_push) begin
                w_out_sel = OUT_BYPASS;
            end else begin
                w_out_sel = OUT_BUBBLE;
            end
        end
    end

    assign w_mem_we    = w_enq && (rst != RstEnable) && !i_flush;
    assign w_head_pc   = w_head[DATA_W-1 -: ADDR_W];
    assign w_head_inst = w_head[INST_W-1:0];

    if_id_queue_sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_mem_we),
        .i_waddr   (r_wr_ptr),
        .i_wdata   ({i_if_pc, i_if_inst}),
        .i_raddr   (r_rd_ptr),
        .o_rdata_c (w_head)
    );

    // Pointers and count; if_ready is registered so it never sees id_stall
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_if_ready <= 1'b1;
        end else if (i_flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_if_ready <= 1'b1;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_if_ready <= (w_count_nxt != CNT_W'(DEPTH));
        end
    end

    // ID-side output register; a bubble is an all-zero word with valid low
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= ADDR_W'(ZeroWord);
            r_id_inst  <= INST_W'(ZeroWord);
        end else if (i_flush) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= ADDR_W'(ZeroWord);
            r_id_inst  <= INST_W'(ZeroWord);
        end else begin
            unique case (w_out_sel)
                OUT_HEAD: begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= w_head_pc;
                    r_id_inst  <= w_head_inst;
                end
                OUT_BYPASS: begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= i_if_pc;
                    r_id_inst  <= i_if_inst;
                end
                OUT_BUBBLE: begin
                    r_id_valid <= 1'b0;
                    r_id_pc    <= ADDR_W'(ZeroWord);
                    r_id_inst  <= INST_W'(ZeroWord);
                end
                default: begin
                    r_id_valid <= r_id_valid;
                    r_id_pc    <= r_id_pc;
                    r_id_inst  <= r_id_inst;
                end
            endcase
        end
    end

    assign o_if_ready = r_if_ready;
    assign o_id_valid = r_id_valid;
    assign o_id_pc    = r_id_pc;
    assign o_id_inst  = r_id_inst;
    assign o_count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a queue-based reference model is checked
// every cycle, with literal expectations at key points and an order scoreboard.
module tb_if_id_queue;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              i_flush;
    logic              i_if_valid;
    logic [ADDR_W-1:0] i_if_pc;
    logic [INST_W-1:0] i_if_inst;
    logic              o_if_ready;
    logic              i_id_stall;
    logic              o_id_valid;
    logic [ADDR_W-1:0] o_id_pc;
    logic [INST_W-1:0] o_id_inst;
    logic [CNT_W-1:0]  o_count;

    if_id_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_if_valid (i_if_valid),
        .i_if_pc    (i_if_pc),
        .i_if_inst  (i_if_inst),
        .o_if_ready (o_if_ready),
        .i_id_stall (i_id_stall),
        .o_id_valid (o_id_valid),
        .o_id_pc    (o_id_pc),
        .o_id_inst  (o_id_inst),
        .o_count    (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents plus what ID should be showing
    logic [63:0] mq[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_inst  = 32'h0;
    logic        m_acc;
    logic [31:0] acc_q[$];
    logic [31:0] dlv_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] pc, input logic [31:0] inst, input logic s);
        logic [63:0] e;
        logic        push;
        rst        = r;
        i_flush    = f;
        i_if_valid = v;
        i_if_pc    = pc;
        i_if_inst  = inst;
        i_id_stall = s;
        m_acc      = 1'b0;
        if (r || f) begin
            mq.delete();
            m_valid = 1'b0;
            m_pc    = 32'h0;
            m_inst  = 32'h0;
        end else begin
            push  = v && (mq.size() < int'(DEPTH));
            m_acc = push;
            if (push) acc_q.push_back(pc);
            if (!s) begin
                if (mq.size() > 0) begin
                    e       = mq.pop_front();
                    m_valid = 1'b1;
                    m_pc    = e[63:32];
                    m_inst  = e[31:0];
                    if (push) mq.push_back({pc, inst});
                end else if (push) begin
                    m_valid = 1'b1;
                    m_pc    = pc;
                    m_inst  = inst;
                end else begin
                    m_valid = 1'b0;
                    m_pc    = 32'h0;
                    m_inst  = 32'h0;
                end
            end else if (push) begin
                mq.push_back({pc, inst});
            end
        end
        @(posedge clk);
        #1;
        chk("id_valid", 32'(o_id_valid), 32'(m_valid));
        chk("id_pc", o_id_pc, m_pc);
        chk("id_inst", o_id_inst, m_inst);
        chk("count", 32'(o_count), 32'(mq.size()));
        chk("if_ready", 32'(o_if_ready), 32'(mq.size() < int'(DEPTH)));
        if (!r && !f && !s && o_id_valid) dlv_q.push_back(o_id_pc);
    endtask

    initial begin
        logic [31:0] pcv;
        int          sent;
        rst = 1'b1; i_flush = 1'b0; i_if_valid = 1'b0;
        i_if_pc = '0; i_if_inst = '0; i_id_stall = 1'b0;

        // Reset with fetch active
        step(1, 0, 1, 32'h50, 32'hDEAD_0050, 0);
        step(1, 0, 1, 32'h54, 32'hDEAD_0054, 0);
        chk("rst_id_valid", 32'(o_id_valid), 32'd0);
        chk("rst_id_inst", o_id_inst, 32'h0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_if_ready", 32'(o_if_ready), 32'd1);

        // Flow-through: one-cycle latency, queue stays empty
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 32'h100 + 32'(4 * i), 32'h0000_1000 + 32'(i), 0);
            if (i == 0) chk("flow_first_pc", o_id_pc, 32'h100);
            chk("flow_count", 32'(o_count), 32'd0);
        end
        chk("flow_last_pc", o_id_pc, 32'h10C);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        chk("flow_bubble_valid", 32'(o_id_valid), 32'd0);

        // Stall fill: six offered, four accepted
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 32'h200 + 32'(4 * i), 32'h0000_2000 + 32'(i), 1);
            if (i == 3) begin
                chk("fill_count4", 32'(o_count), 32'd4);
                chk("fill_ready0", 32'(o_if_ready), 32'd0);
            end
        end
        chk("fill_count_held", 32'(o_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 32'h0, 32'h0, 0);
            chk("drain_pc", o_id_pc, 32'h200 + 32'(4 * i));
        end
        step(0, 0, 0, 32'h0, 32'h0, 0);
        chk("drain_bubble_inst", o_id_inst, 32'h0);

        // Full with simultaneous pop: the offered word is refused
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h300 + 32'(4 * i), 32'h0000_3000 + 32'(i), 1);
        step(0, 0, 1, 32'h3F0, 32'h0000_30F0, 0);
        chk("fullpop_count", 32'(o_count), 32'd3);
        chk("fullpop_ready", 32'(o_if_ready), 32'd1);
        chk("fullpop_pc", o_id_pc, 32'h300);

        // Flush with fetch active: everything discarded
        step(0, 1, 1, 32'h400, 32'h0000_4000, 0);
        chk("flush_count", 32'(o_count), 32'd0);
        chk("flush_valid", 32'(o_id_valid), 32'd0);
        chk("flush_inst", o_id_inst, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        chk("flush_no_ghost", 32'(o_id_valid), 32'd0);

        // Wrap-around stream with random stalls
        acc_q.delete();
        dlv_q.delete();
        pcv  = 32'h500;
        sent = 0;
        for (int it = 0; it < 200 && sent < 3 * int'(DEPTH); it++) begin
            step(0, 0, 1, pcv, ~pcv, 1'($urandom_range(0, 1)));
            if (m_acc) begin
                pcv  = pcv + 32'd4;
                sent = sent + 1;
            end
        end
        chk("wrap_budget", 32'(sent), 32'(3 * DEPTH));
        for (int i = 0; i < int'(DEPTH) + 2; i++) step(0, 0, 0, 32'h0, 32'h0, 0);
        chk("sb_len", 32'(dlv_q.size()), 32'(3 * DEPTH));
        for (int i = 0; i < dlv_q.size() && i < acc_q.size(); i++) begin
            chk("sb_order", dlv_q[i], acc_q[i]);
            chk("sb_pc_lit", dlv_q[i], 32'h500 + 32'(4 * i));
        end

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h600 + 32'(4 * i), 32'h0000_6000 + 32'(i), 1);
        step(1, 0, 1, 32'h700, 32'h0000_7000, 0);
        chk("midrst_count", 32'(o_count), 32'd0);
        step(0, 0, 0, 32'h0, 32'h0, 0);
        chk("midrst_empty", 32'(o_id_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
